// File: rtl/ram_responder_if.sv
// ram_responder_if: request/response port between a memory initiator and the ram_responder
interface ram_responder_if;
    logic [31:0] data;
    logic [31:0] addr;
    logic        wr;
    logic        response;
    logic [31:0] out;
    logic        err;
    modport master (output data, addr, wr, input response, out, err);
    modport slave  (input data, addr, wr, output response, out, err);
endinterface

// File: rtl/ram_responder.sv
// ram_responder: latency-modelled word RAM behind a hold-until-response port; optional RAM_RANGE_CHECK_EN flags out-of-range addresses
module ram_responder #(
    parameter int DEPTH   = 1024,
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 4
) (
    input logic clk,
    input logic rst,
    ram_responder_if.slave bus
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t state, state_n;
    logic [31:0] mem [DEPTH];
    logic [31:0] data_q, addr_q, out_q;
    logic wr_q, change, load, complete, in_range;
    logic [7:0] cnt;
    logic [ADDR_W-1:0] idx;
`ifdef RAM_RANGE_CHECK_EN
    logic err_q;
`endif
    // request decode: a change is any difference from the latched request
    always_comb begin
        change   = {bus.data, bus.addr, bus.wr} != {data_q, addr_q, wr_q};
        load     = state == IDLE || (state != IDLE && change);
        complete = state == BUSY && !change && cnt == 8'd0;
        idx      = addr_q[ADDR_W+1:2];
`ifdef RAM_RANGE_CHECK_EN
        in_range = addr_q[31:ADDR_W+2] == '0;
`else
        in_range = 1'b1;
`endif
    end
    // state register
    always_ff @(posedge clk)
        if (rst) state <= IDLE;
        else     state <= state_n;
    // next state: IDLE always starts a request; any change restarts the count
    always_comb
        state_n = state == IDLE ? BUSY :
                  change        ? BUSY :
                  complete      ? DONE : state;
    // outputs: response is simply being in DONE
    always_comb begin
        bus.response = state == DONE;
        bus.out      = out_q;
`ifdef RAM_RANGE_CHECK_EN
        bus.err      = err_q;
`else
        bus.err      = 1'b0;
`endif
    end
    // request latch, latency counter and read/echo data
    always_ff @(posedge clk) begin
        if (rst) begin
            {data_q, addr_q, wr_q} <= '0;
            cnt                    <= '0;
            out_q                  <= '0;
`ifdef RAM_RANGE_CHECK_EN
            err_q                  <= 1'b0;
`endif
        end else begin
            if (load) begin
                {data_q, addr_q, wr_q} <= {bus.data, bus.addr, bus.wr};
                cnt                    <= 8'(LATENCY - 1);
            end else if (state == BUSY && cnt != 8'd0) begin
                cnt <= cnt - 8'd1;
            end
            if (complete) begin
                out_q <= !in_range ? '0 : wr_q ? data_q : mem[idx];
`ifdef RAM_RANGE_CHECK_EN
                err_q <= !in_range;
`endif
            end
        end
    end
    // array write happens only at completion of an in-range write; never cleared by reset
    always_ff @(posedge clk)
        if (!rst && complete && wr_q && in_range) mem[idx] <= data_q;
endmodule

// File: tb/tb_ram_responder.sv
// tb_ram_responder: directed scoreboard bench for ram_responder (DEPTH=1024, LATENCY=4)
module tb_ram_responder;
    localparam int LAT = 4;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int vecs = 0;
    int fails = 0;
    logic [32:0] sb [$];
    logic [32:0] exp_v;
    logic prev = 1'b0;

    ram_responder_if bus ();
    ram_responder #(.DEPTH(1024), .ADDR_W(10), .LATENCY(LAT)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic req(input logic w, input logic [31:0] a, input logic [31:0] d);
        bus.wr = w;
        bus.addr = a;
        bus.data = d;
    endtask

    task automatic push(input logic e, input logic [31:0] o);
        sb.push_back({e, o});
    endtask

    task automatic wait_resp(input string name, input int exp_n);
        int n = 0;
        while (n < 50) begin
            @(negedge clk);
            n++;
            if (bus.response) break;
        end
        if (!bus.response) chk({name, "_timeout"}, {31'b0, bus.response}, 32'd1);
        else chk(name, n, exp_n);
    endtask

    // monitor: every rising response consumes one expected completion
    always @(negedge clk) begin
        if (bus.response && !prev) begin
            if (sb.size() == 0) begin
                vecs++;
                fails++;
                $display("FAIL sb_unexpected: got response with out %h, expected none", bus.out);
            end else begin
                exp_v = sb.pop_front();
                chk("sb_out", bus.out, exp_v[31:0]);
                chk("sb_err", {31'b0, bus.err}, {31'b0, exp_v[32]});
            end
        end
        prev = bus.response;
    end

    initial begin
        req(1'b1, 32'h10, 32'hDEADBEEF);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_resp", {31'b0, bus.response}, 32'd0);
        chk("rst_out", bus.out, 32'd0);
        chk("rst_err", {31'b0, bus.err}, 32'd0);
        // 1: write held from reset release
        push(1'b0, 32'hDEADBEEF);
        rst = 1'b0;
        wait_resp("t1_lat", LAT + 1);
        // 2: read back the same address
        req(1'b0, 32'h10, 32'hDEADBEEF);
        push(1'b0, 32'hDEADBEEF);
        wait_resp("t2_lat", LAT + 1);
        // 3: write restarted by a data change before E2
        req(1'b1, 32'h20, 32'h1);
        @(negedge clk);
        chk("t3_busy0", {31'b0, bus.response}, 32'd0);
        @(negedge clk);
        chk("t3_busy1", {31'b0, bus.response}, 32'd0);
        bus.data = 32'h2;
        push(1'b0, 32'h2);
        wait_resp("t3_lat", LAT + 1);
        req(1'b0, 32'h20, 32'h2);
        push(1'b0, 32'h2);
        wait_resp("t3_rd_lat", LAT + 1);
        // 4: hold in DONE, then change address
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("t4_hold_resp", {31'b0, bus.response}, 32'd1);
            chk("t4_hold_out", bus.out, 32'h2);
        end
        req(1'b0, 32'h10, 32'h2);
        push(1'b0, 32'hDEADBEEF);
        @(negedge clk);
        chk("t4_drop", {31'b0, bus.response}, 32'd0);
        chk("t4_out_kept", bus.out, 32'h2);
        wait_resp("t4_lat", LAT);
        // 5: aliasing / range check on index 0
        req(1'b1, 32'h0, 32'h11);
        push(1'b0, 32'h11);
        wait_resp("t5_init", LAT + 1);
        req(1'b1, 32'h1000, 32'hA5);
`ifdef RAM_RANGE_CHECK_EN
        push(1'b1, 32'h0);
`else
        push(1'b0, 32'hA5);
`endif
        wait_resp("t5_wr", LAT + 1);
        req(1'b0, 32'h0, 32'h0);
`ifdef RAM_RANGE_CHECK_EN
        push(1'b0, 32'h11);
`else
        push(1'b0, 32'hA5);
`endif
        wait_resp("t5_rd", LAT + 1);
        // 6: reset during an in-flight write
        req(1'b1, 32'h30, 32'h55);
        push(1'b0, 32'h55);
        wait_resp("t6_init", LAT + 1);
        req(1'b1, 32'h30, 32'h77);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("t6_rst_resp", {31'b0, bus.response}, 32'd0);
        chk("t6_rst_out", bus.out, 32'd0);
        req(1'b0, 32'h30, 32'h0);
        push(1'b0, 32'h55);
        rst = 1'b0;
        wait_resp("t6_rd", LAT + 1);
        repeat (3) @(negedge clk);
        chk("sb_empty", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
        $finish;
    end
endmodule
